// File: rtl/serial_adder_if.sv
// Bundles the request/result signals of serial_adder together with the
// bit-level link to the external single-bit full adder.
interface serial_adder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             fa_a;
   logic             fa_b;
   logic             fa_cin;
   logic             fa_s;
   logic             fa_cout;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   // master: the requester together with the full adder it supplies
   modport master (
      output start, a, b, cin, fa_s, fa_cout,
      input  fa_a, fa_b, fa_cin, busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, a, b, cin, fa_s, fa_cout,
      output fa_a, fa_b, fa_cin, busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: streams operands LSB-first through an external
// full adder, one bit per clock, and presents sum/cout/ovf with a done pulse.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);

   localparam int unsigned     CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_sum;
   logic [WIDTH-1:0] w_sum_nx;
   logic             r_carry;
   logic             r_cout;
   logic             r_ovf;
   logic [CW-1:0]    r_cnt;
   logic             w_accept;
   logic             w_run;

   assign w_run    = (r_state == S_RUN);
   assign w_accept = bus.start && !w_run;
   assign w_sum_nx = (r_sum >> 1) | (WIDTH'(bus.fa_s) << (WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next = S_RUN;
         S_RUN:   if (r_cnt == LAST) w_next = S_DONE;
         S_DONE:  w_next = bus.start ? S_RUN : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy   = w_run;
      bus.done   = (r_state == S_DONE);
      bus.fa_a   = w_run & r_a_sh[0];
      bus.fa_b   = w_run & r_b_sh[0];
      bus.fa_cin = w_run & r_carry;
   end

   // cout/ovf are captured on the final bit edge (r_carry is still the carry
   // into the MSB there), so they stay put through IDLE until the next start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_a_sh  <= bus.a;
         r_b_sh  <= bus.b;
         r_sum   <= '0;
         r_carry <= bus.cin;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_cnt   <= '0;
      end else if (w_run) begin
         r_sum   <= w_sum_nx;
         r_a_sh  <= r_a_sh >> 1;
         r_b_sh  <= r_b_sh >> 1;
         r_carry <= bus.fa_cout;
         r_cnt   <= r_cnt + CW'(1);
         if (r_cnt == LAST) begin
            r_cout <= bus.fa_cout;
            r_ovf  <= r_carry ^ bus.fa_cout;
         end
      end
   end

   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;
   assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH 8, 1 and 32, each DUT paired
// with a behavioural full adder; results checked against integer arithmetic.
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(8))  if8 ();
   serial_adder_if #(.WIDTH(1))  if1 ();
   serial_adder_if #(.WIDTH(32)) if32 ();

   assign if8.fa_s     = if8.fa_a ^ if8.fa_b ^ if8.fa_cin;
   assign if8.fa_cout  = (if8.fa_a & if8.fa_b) | (if8.fa_a & if8.fa_cin) | (if8.fa_b & if8.fa_cin);
   assign if1.fa_s     = if1.fa_a ^ if1.fa_b ^ if1.fa_cin;
   assign if1.fa_cout  = (if1.fa_a & if1.fa_b) | (if1.fa_a & if1.fa_cin) | (if1.fa_b & if1.fa_cin);
   assign if32.fa_s    = if32.fa_a ^ if32.fa_b ^ if32.fa_cin;
   assign if32.fa_cout = (if32.fa_a & if32.fa_b) | (if32.fa_a & if32.fa_cin) | (if32.fa_b & if32.fa_cin);

   serial_adder #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
   serial_adder #(.WIDTH(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   serial_adder #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

   int n_tests = 0;
   int n_fail  = 0;
   int n_push8 = 0, n_done8 = 0;
   int n_push1 = 0, n_done1 = 0;
   int n_push32 = 0, n_done32 = 0;
   logic [33:0] q8[$];
   logic [33:0] q1[$];
   logic [33:0] q32[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // {ovf, cout, sum} from plain integer addition and the sign rule
   function automatic logic [33:0] model(input int unsigned w, input logic [31:0] a,
                                         input logic [31:0] b, input logic c);
      logic [63:0] m, s;
      logic        co, ov;
      m  = (64'd1 << w) - 64'd1;
      s  = ({32'd0, a} & m) + ({32'd0, b} & m) + {63'd0, c};
      co = s[w];
      s  = s & m;
      ov = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
      return {ov, co, s[31:0]};
   endfunction

   function automatic logic [33:0] res(input int unsigned w);
      case (w)
         8:       return {if8.ovf, if8.cout, 24'd0, if8.sum};
         1:       return {if1.ovf, if1.cout, 31'd0, if1.sum};
         default: return {if32.ovf, if32.cout, if32.sum};
      endcase
   endfunction

   function automatic logic [1:0] bd(input int unsigned w);
      case (w)
         8:       return {if8.busy, if8.done};
         1:       return {if1.busy, if1.done};
         default: return {if32.busy, if32.done};
      endcase
   endfunction

   function automatic logic [2:0] fa(input int unsigned w);
      case (w)
         8:       return {if8.fa_a, if8.fa_b, if8.fa_cin};
         1:       return {if1.fa_a, if1.fa_b, if1.fa_cin};
         default: return {if32.fa_a, if32.fa_b, if32.fa_cin};
      endcase
   endfunction

   task automatic drive(input int unsigned w, input logic st, input logic [31:0] a,
                        input logic [31:0] b, input logic c);
      case (w)
         8:       begin if8.start = st;  if8.a = a[7:0];  if8.b = b[7:0];  if8.cin = c;  end
         1:       begin if1.start = st;  if1.a = a[0:0];  if1.b = b[0:0];  if1.cin = c;  end
         default: begin if32.start = st; if32.a = a;      if32.b = b;      if32.cin = c; end
      endcase
   endtask

   task automatic push(input int unsigned w, input logic [33:0] e);
      case (w)
         8:       begin q8.push_back(e);  n_push8++;  end
         1:       begin q1.push_back(e);  n_push1++;  end
         default: begin q32.push_back(e); n_push32++; end
      endcase
   endtask

   // one operation; rp re-pulses start (with other operands) mid-RUN
   task automatic run(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                      input logic c, input bit rp);
      int          cyc, nbusy;
      logic [33:0] e;
      logic [1:0]  sbd;
      e = model(w, a, b, c);
      @(posedge clk); #1;
      drive(w, 1'b1, a, b, c);
      push(w, e);
      @(posedge clk); #1;
      drive(w, 1'b0, a, b, c);
      cyc = 0; nbusy = 0;
      do begin
         @(negedge clk);
         cyc++;
         sbd = bd(w);
         if (sbd[1]) nbusy++;
         if (rp && cyc == 3) drive(w, 1'b1, 32'h1, 32'h1, 1'b0);
         if (rp && cyc == 4) drive(w, 1'b0, 32'h1, 32'h1, 1'b0);
      end while (!sbd[0] && cyc < 80);
      chk($sformatf("w%0d start-to-done edges", w), cyc - 1, w);
      chk($sformatf("w%0d busy cycles", w), nbusy, w);
      chk($sformatf("w%0d fa idle at done", w), fa(w), 0);
      repeat (3) @(negedge clk);
      chk($sformatf("w%0d result held in idle", w), res(w), e);
      chk($sformatf("w%0d idle busy/done", w), bd(w), 0);
      chk($sformatf("w%0d fa idle", w), fa(w), 0);
   endtask

   always @(negedge clk) begin
      if (if8.done === 1'b1) begin
         n_done8++;
         if (q8.size() == 0) chk("w8 spurious done", n_done8, n_push8);
         else chk("w8 result", res(8), q8.pop_front());
      end
   end

   always @(negedge clk) begin
      if (if1.done === 1'b1) begin
         n_done1++;
         if (q1.size() == 0) chk("w1 spurious done", n_done1, n_push1);
         else chk("w1 result", res(1), q1.pop_front());
      end
   end

   always @(negedge clk) begin
      if (if32.done === 1'b1) begin
         n_done32++;
         if (q32.size() == 0) chk("w32 spurious done", n_done32, n_push32);
         else chk("w32 result", res(32), q32.pop_front());
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [7:0]  ha [4];
      logic [7:0]  hb [4];
      logic        hc [4];
      int          cnt, nd, nb;

      rst_n = 1'b0;
      drive(8, 1'b0, 0, 0, 1'b0);
      drive(1, 1'b0, 0, 0, 1'b0);
      drive(32, 1'b0, 0, 0, 1'b0);
      repeat (2) @(negedge clk);
      chk("w8 reset outputs", {bd(8), fa(8), res(8)}, 0);
      chk("w32 reset outputs", {bd(32), fa(32), res(32)}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run(8, 32'h5A, 32'h33, 1'b0, 1'b0);
      run(8, 32'hFF, 32'h01, 1'b0, 1'b0);
      run(8, 32'h7F, 32'h00, 1'b1, 1'b0);
      run(8, 32'h10, 32'h20, 1'b0, 1'b1);
      repeat (15) @(negedge clk);
      chk("w8 no extra done after re-pulse", n_done8, n_push8);

      for (int i = 0; i < 12; i++)
         run(8, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);

      // start held high: a new operand set is presented at every done
      ha[0] = 8'h80; hb[0] = 8'h80; hc[0] = 1'b0;
      ha[1] = 8'h12; hb[1] = 8'h34; hc[1] = 1'b1;
      ha[2] = 8'($urandom); hb[2] = 8'($urandom); hc[2] = 1'b0;
      ha[3] = 8'($urandom); hb[3] = 8'($urandom); hc[3] = 1'b1;
      @(posedge clk); #1;
      drive(8, 1'b1, 32'(ha[0]), 32'(hb[0]), hc[0]);
      push(8, model(8, 32'(ha[0]), 32'(hb[0]), hc[0]));
      for (int k = 0; k < 4; k++) begin
         cnt = 0;
         do begin
            @(negedge clk);
            cnt++;
         end while (!if8.done && cnt < 80);
         if (k == 0) chk("w8 held-start first done", cnt, 10);
         else        chk("w8 back-to-back gap", cnt, 9);
         if (k < 3) begin
            drive(8, 1'b1, 32'(ha[k+1]), 32'(hb[k+1]), hc[k+1]);
            push(8, model(8, 32'(ha[k+1]), 32'(hb[k+1]), hc[k+1]));
         end else begin
            drive(8, 1'b0, 0, 0, 1'b0);
         end
      end
      repeat (3) @(negedge clk);

      // asynchronous reset between edges while the adder is on bit 3
      @(posedge clk); #1;
      drive(8, 1'b1, 32'hFF, 32'hFF, 1'b1);
      @(posedge clk); #1;
      drive(8, 1'b0, 32'hFF, 32'hFF, 1'b1);
      repeat (3) @(posedge clk);
      #2;
      chk("w8 busy before abort", if8.busy, 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("w8 async reset outputs", {bd(8), fa(8), res(8)}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0; nb = 0;
      repeat (12) begin
         @(negedge clk);
         if (if8.done) nd++;
         if (if8.busy) nb++;
      end
      chk("w8 done after abort", nd, 0);
      chk("w8 busy after abort", nb, 0);
      chk("w8 result after abort", res(8), 0);

      for (int i = 0; i < 8; i++)
         run(1, 32'(i & 1), 32'((i >> 1) & 1), 1'((i >> 2) & 1), 1'b0);

      run(32, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      run(32, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         run(32, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);

      repeat (5) @(negedge clk);
      chk("w8 done count", n_done8, n_push8);
      chk("w1 done count", n_done1, n_push1);
      chk("w32 done count", n_done32, n_push32);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
